scaler_channel_scheduler: RTL and testbench

//  Time-shares one voltage_scaler instance across the 13 measurement channels.
//  - Round-robin arbitration of channel sample requests; grants one channel per cycle.
//  - Feeds the winning sample to the scaler and tags it through the scaler latency.
//  - Writes each scaled result into a per-channel result bank for the display path.
//  - Pulses frame_done once every enabled channel has been refreshed.

---
 rtl/scaler_channel_scheduler_pkg.sv | 29 ++
 rtl/scaler_channel_scheduler_rr_arbiter.sv | 36 +++
 rtl/scaler_channel_scheduler.sv | 106 ++++++++++
 tb/tb_scaler_channel_scheduler.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_channel_scheduler_pkg.sv
// Shared instrument parameters and helpers for the scaler channel scheduler.
package scaler_channel_scheduler_pkg;

  localparam int unsigned N_CH    = 13;
  localparam int unsigned DW      = 12;
  localparam int unsigned CH_W    = 4;
  localparam int unsigned SCL_LAT = 4;

  // One tag entry rides alongside the scl_in register, then one per scaler edge,
  // so the final entry lines up with scl_out after edge E(SCL_LAT).
  localparam int unsigned TAG_DEPTH = SCL_LAT + 1;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
  } tag_t;

  function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    logic [N_CH-1:0] oh;
    oh     = '0;
    oh[ch] = 1'b1;
    return oh;
  endfunction

  function automatic logic [CH_W-1:0] ch_next(input logic [CH_W-1:0] ch);
    return (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
  endfunction

endpackage

// File: rtl/scaler_channel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible channel at or above ptr, wrapping.
module rr_arbiter
  import scaler_channel_scheduler_pkg::*;
#(
  parameter int unsigned N  = N_CH,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  // Two passes: channels from ptr upward first, then wrap to the bottom.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && eligible[i] && (i >= 32'(ptr))) begin
        grant[i] = 1'b1;
        index    = IW'(i);
        any      = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && eligible[i]) begin
        grant[i] = 1'b1;
        index    = IW'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scaler_channel_scheduler.sv
// Time-shares one voltage_scaler across all measurement channels and banks the results.
module scaler_channel_scheduler
  import scaler_channel_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    req,
  input  logic [N_CH*DW-1:0] sample_flat,
  input  logic [N_CH-1:0]    ch_en,
  output logic [N_CH-1:0]    ack,
  output logic [DW-1:0]      scl_in,
  input  logic [DW-1:0]      scl_out,
  output logic [N_CH*DW-1:0] res_flat,
  output logic               res_valid,
  output logic [CH_W-1:0]    res_ch,
  output logic               frame_done
);

  logic [DW-1:0]   sample [N_CH];
  logic [DW-1:0]   bank_q [N_CH];
  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] grant;
  logic [CH_W-1:0] win;
  logic            any;
  logic [CH_W-1:0] ptr_q;
  tag_t            tag_q [TAG_DEPTH];
  tag_t            tag_last;
  logic [N_CH-1:0] updated_q;
  logic [N_CH-1:0] updated_next;
  logic            frame_complete;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign sample[k]             = sample_flat[k*DW +: DW];
    assign res_flat[k*DW +: DW]  = bank_q[k];
  end

  // Last cycle's ack masks the winner so a requester gets a cycle to drop req.
  assign eligible = req & ch_en & ~ack;

  rr_arbiter #(
    .N  (N_CH),
    .IW (CH_W)
  ) u_rr_arbiter (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant),
    .index    (win),
    .any      (any)
  );

  // Grant stage: ack pulse, scaler input register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack    <= '0;
      scl_in <= '0;
      ptr_q  <= '0;
    end else begin
      ack <= grant;
      if (any) begin
        scl_in <= sample[win];
        ptr_q  <= ch_next(win);
      end
    end
  end

  // Tag pipeline carrying the channel index through the scaler latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_t'{valid: any, ch: win};
      for (int unsigned i = 1; i < TAG_DEPTH; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_last       = tag_q[TAG_DEPTH-1];
  assign updated_next   = updated_q | ch_onehot(tag_last.ch);
  // Uses the live enable mask, so disabled channels drop out of the check at once.
  assign frame_complete = tag_last.valid && (ch_en != '0) && ((updated_next & ch_en) == ch_en);

  // Writeback into the result bank plus frame-refresh tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        bank_q[i] <= '0;
      end
      res_valid  <= 1'b0;
      res_ch     <= '0;
      frame_done <= 1'b0;
      updated_q  <= '0;
    end else begin
      res_valid  <= tag_last.valid;
      frame_done <= frame_complete;
      if (tag_last.valid) begin
        bank_q[tag_last.ch] <= scl_out;
        res_ch              <= tag_last.ch;
        updated_q           <= frame_complete ? '0 : updated_next;
      end
    end
  end

endmodule

// File: tb/tb_scaler_channel_scheduler.sv
// Self-checking bench for scaler_channel_scheduler with a behavioural voltage scaler.
module tb_scaler_channel_scheduler;
  import scaler_channel_scheduler_pkg::*;

  localparam int unsigned MUL = 25177;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_CH-1:0]    req = '0;
  logic [N_CH*DW-1:0] sample_flat = '0;
  logic [N_CH-1:0]    ch_en = '0;
  logic [N_CH-1:0]    ack;
  logic [DW-1:0]      scl_in;
  logic [DW-1:0]      scl_out;
  logic [N_CH*DW-1:0] res_flat;
  logic               res_valid;
  logic [CH_W-1:0]    res_ch;
  logic               frame_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  scaler_channel_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .sample_flat (sample_flat),
    .ch_en       (ch_en),
    .ack         (ack),
    .scl_in      (scl_in),
    .scl_out     (scl_out),
    .res_flat    (res_flat),
    .res_valid   (res_valid),
    .res_ch      (res_ch),
    .frame_done  (frame_done)
  );

  // Full-scale 4095 counts -> 3299 mV.
  function automatic logic [DW-1:0] scale(input logic [DW-1:0] x);
    int unsigned p;
    p = 32'(x) * MUL;
    return DW'(p / 31250);
  endfunction

  function automatic logic [N_CH-1:0] ch_bit(input int k);
    logic [N_CH-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [N_CH-1:0] elig, input int ptr);
    for (int d = 0; d < int'(N_CH); d++) begin
      if (elig[(ptr + d) % int'(N_CH)]) return (ptr + d) % int'(N_CH);
    end
    return -1;
  endfunction

  // Behavioural voltage_scaler: SCL_LAT registered stages after scl_in.
  logic [DW-1:0] scl_pipe [SCL_LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SCL_LAT); i++) scl_pipe[i] <= '0;
    end else begin
      scl_pipe[0] <= scale(scl_in);
      for (int i = 1; i < int'(SCL_LAT); i++) scl_pipe[i] <= scl_pipe[i-1];
    end
  end
  assign scl_out = scl_pipe[SCL_LAT-1];

  // Reference model: grants by round-robin search, results due SCL_LAT+1 edges later.
  typedef struct {
    int            due;
    int            ch;
    logic [DW-1:0] val;
  } pend_t;

  pend_t              m_q[$];
  logic [N_CH-1:0]    m_ack = '0;
  int                 m_ptr = 0;
  int                 m_cyc = 0;
  logic [DW-1:0]      m_scl = '0;
  logic [N_CH*DW-1:0] m_bank = '0;
  logic               m_rv = 1'b0;
  logic [CH_W-1:0]    m_rch = '0;
  logic               m_fd = 1'b0;
  logic [N_CH-1:0]    m_upd = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_ack  <= '0;
      m_ptr  <= 0;
      m_cyc  <= 0;
      m_scl  <= '0;
      m_bank <= '0;
      m_rv   <= 1'b0;
      m_rch  <= '0;
      m_fd   <= 1'b0;
      m_upd  <= '0;
      m_q.delete();
    end else begin
      automatic int              w = rr_pick(req & ch_en & ~m_ack, m_ptr);
      automatic logic [N_CH-1:0] seen;
      automatic pend_t           p;
      m_rv <= 1'b0;
      m_fd <= 1'b0;
      if (m_q.size() != 0 && m_q[0].due == m_cyc) begin
        p = m_q[0];
        m_q.pop_front();
        seen = m_upd | ch_bit(p.ch);
        m_bank[p.ch*DW +: DW] <= p.val;
        m_rv  <= 1'b1;
        m_rch <= CH_W'(p.ch);
        if (ch_en != '0 && (seen & ch_en) == ch_en) begin
          m_fd  <= 1'b1;
          m_upd <= '0;
        end else begin
          m_upd <= seen;
        end
      end
      if (w >= 0) begin
        m_ack <= ch_bit(w);
        m_scl <= sample_flat[w*DW +: DW];
        m_ptr <= (w + 1) % int'(N_CH);
        m_q.push_back('{due: m_cyc + int'(SCL_LAT) + 1, ch: w,
                        val: scale(sample_flat[w*DW +: DW])});
      end else begin
        m_ack <= '0;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ch_en = '1;
    for (int k = 0; k < int'(N_CH); k++) sample_flat[k*DW +: DW] = DW'($urandom_range(0, 4095));
    for (int c = 0; c < 12; c++) begin
      req = N_CH'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ack, scl_in, res_valid, res_ch, frame_done} !== 31'd0) begin
      n_errors++;
      $display("FAIL reset outputs: got %h required 0", {ack, scl_in, res_valid, res_ch, frame_done});
    end
    n_checks++;
    if (res_flat !== '0) begin
      n_errors++;
      $display("FAIL reset bank: got %h required 0", res_flat);
    end
    rst = 1'b0;
    req = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({ack, scl_in, res_valid, res_ch, frame_done} !== {m_ack, m_scl, m_rv, m_rch, m_fd}) begin
        n_errors++;
        $display("FAIL reset idle c%0d: got %h required %h", c,
                 {ack, scl_in, res_valid, res_ch, frame_done}, {m_ack, m_scl, m_rv, m_rch, m_fd});
      end
    end
  endtask

  task automatic test_single();
    int ack_cnt = 0;
    int ack_at  = -1;
    int rv_at   = -1;
    do_reset();
    ch_en = '1;
    sample_flat[5*DW +: DW] = 12'd4095;
    req = ch_bit(5);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_checks += 2;
      if ({ack, scl_in, res_valid, res_ch, frame_done} !== {m_ack, m_scl, m_rv, m_rch, m_fd}) begin
        n_errors++;
        $display("FAIL single c%0d outputs: got %h required %h", c,
                 {ack, scl_in, res_valid, res_ch, frame_done}, {m_ack, m_scl, m_rv, m_rch, m_fd});
      end
      if (res_flat !== m_bank) begin
        n_errors++;
        $display("FAIL single c%0d bank: got %h required %h", c, res_flat, m_bank);
      end
      if (ack[5]) begin
        ack_cnt++;
        if (ack_at < 0) ack_at = c;
      end
      if (res_valid && rv_at < 0) rv_at = c;
      req &= ~ack;
    end
    n_checks += 4;
    if (ack_cnt !== 1) begin
      n_errors++;
      $display("FAIL single ack count: got %0d required 1", ack_cnt);
    end
    if (ack_at < 0 || rv_at - ack_at !== 5) begin
      n_errors++;
      $display("FAIL single latency: got %0d required 5", rv_at - ack_at);
    end
    if (res_ch !== 4'd5) begin
      n_errors++;
      $display("FAIL single res_ch: got %0d required 5", res_ch);
    end
    if (res_flat[5*DW +: DW] !== 12'd3299) begin
      n_errors++;
      $display("FAIL single slot5: got %0d required 3299", res_flat[5*DW +: DW]);
    end
  endtask

  task automatic test_all_channels();
    int rv_cnt = 0;
    int rv_first = -1;
    int rv_last = -1;
    int fd_cnt = 0;
    int fd_ch = -1;
    do_reset();
    ch_en = '1;
    for (int k = 0; k < int'(N_CH); k++) sample_flat[k*DW +: DW] = 12'd2048;
    req = '1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      n_checks += 2;
      if ({ack, scl_in, res_valid, res_ch, frame_done} !== {m_ack, m_scl, m_rv, m_rch, m_fd}) begin
        n_errors++;
        $display("FAIL all c%0d outputs: got %h required %h", c,
                 {ack, scl_in, res_valid, res_ch, frame_done}, {m_ack, m_scl, m_rv, m_rch, m_fd});
      end
      if (res_flat !== m_bank) begin
        n_errors++;
        $display("FAIL all c%0d bank: got %h required %h", c, res_flat, m_bank);
      end
      if (c < int'(N_CH)) begin
        n_checks++;
        if (ack !== ch_bit(c)) begin
          n_errors++;
          $display("FAIL all ack order c%0d: got %h required %h", c, ack, ch_bit(c));
        end
      end
      if (res_valid) begin
        rv_cnt++;
        if (rv_first < 0) rv_first = c;
        rv_last = c;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_ch = int'(res_ch);
      end
      req &= ~ack;
    end
    n_checks += 4;
    if (rv_cnt !== 13 || rv_last - rv_first !== 12) begin
      n_errors++;
      $display("FAIL all res_valid run: got %0d over %0d cycles required 13 over 13",
               rv_cnt, rv_last - rv_first + 1);
    end
    if (fd_cnt !== 1) begin
      n_errors++;
      $display("FAIL all frame_done count: got %0d required 1", fd_cnt);
    end
    if (fd_ch !== 12) begin
      n_errors++;
      $display("FAIL all frame_done channel: got %0d required 12", fd_ch);
    end
    if (res_ch !== 4'd12) begin
      n_errors++;
      $display("FAIL all last res_ch: got %0d required 12", res_ch);
    end
    for (int k = 0; k < int'(N_CH); k++) begin
      n_checks++;
      if (res_flat[k*DW +: DW] !== 12'd1649) begin
        n_errors++;
        $display("FAIL all slot%0d: got %0d required 1649", k, res_flat[k*DW +: DW]);
      end
    end
  endtask

  task automatic test_alternate();
    do_reset();
    ch_en = '1;
    sample_flat[3*DW +: DW] = DW'($urandom_range(0, 4095));
    sample_flat[7*DW +: DW] = DW'($urandom_range(0, 4095));
    req = ch_bit(3) | ch_bit(7);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks += 3;
      if ({ack, scl_in, res_valid, res_ch, frame_done} !== {m_ack, m_scl, m_rv, m_rch, m_fd}) begin
        n_errors++;
        $display("FAIL alt c%0d outputs: got %h required %h", c,
                 {ack, scl_in, res_valid, res_ch, frame_done}, {m_ack, m_scl, m_rv, m_rch, m_fd});
      end
      if (res_flat !== m_bank) begin
        n_errors++;
        $display("FAIL alt c%0d bank: got %h required %h", c, res_flat, m_bank);
      end
      if (ack !== ((c % 2 == 0) ? ch_bit(3) : ch_bit(7))) begin
        n_errors++;
        $display("FAIL alt order c%0d: got %h required %h", c, ack,
                 (c % 2 == 0) ? ch_bit(3) : ch_bit(7));
      end
    end
    req = '0;
  endtask

  task automatic test_single_hold();
    do_reset();
    ch_en = '1;
    sample_flat[9*DW +: DW] = DW'($urandom_range(0, 4095));
    req = ch_bit(9);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_checks += 3;
      if ({ack, scl_in, res_valid, res_ch, frame_done} !== {m_ack, m_scl, m_rv, m_rch, m_fd}) begin
        n_errors++;
        $display("FAIL hold c%0d outputs: got %h required %h", c,
                 {ack, scl_in, res_valid, res_ch, frame_done}, {m_ack, m_scl, m_rv, m_rch, m_fd});
      end
      if (res_flat !== m_bank) begin
        n_errors++;
        $display("FAIL hold c%0d bank: got %h required %h", c, res_flat, m_bank);
      end
      if (ack !== ((c % 2 == 0) ? ch_bit(9) : 13'd0)) begin
        n_errors++;
        $display("FAIL hold ack c%0d: got %h required %h", c, ack,
                 (c % 2 == 0) ? ch_bit(9) : 13'd0);
      end
      if (c >= 5) begin
        n_checks++;
        if (res_valid !== (c % 2 == 1)) begin
          n_errors++;
          $display("FAIL hold res_valid c%0d: got %b required %b", c, res_valid, c % 2 == 1);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_enable_mask();
    int ack1_cnt = 0;
    int fd_cnt = 0;
    int fd_ch = -1;
    do_reset();
    ch_en = 13'h0005;
    for (int k = 0; k < 3; k++) sample_flat[k*DW +: DW] = DW'($urandom_range(0, 4095));
    req = 13'h0007;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      n_checks += 2;
      if ({ack, scl_in, res_valid, res_ch, frame_done} !== {m_ack, m_scl, m_rv, m_rch, m_fd}) begin
        n_errors++;
        $display("FAIL mask c%0d outputs: got %h required %h", c,
                 {ack, scl_in, res_valid, res_ch, frame_done}, {m_ack, m_scl, m_rv, m_rch, m_fd});
      end
      if (res_flat !== m_bank) begin
        n_errors++;
        $display("FAIL mask c%0d bank: got %h required %h", c, res_flat, m_bank);
      end
      if (ack[1]) ack1_cnt++;
      if (frame_done) begin
        fd_cnt++;
        fd_ch = int'(res_ch);
      end
      req &= ~ack;
    end
    n_checks += 3;
    if (ack1_cnt !== 0) begin
      n_errors++;
      $display("FAIL mask ch1 acks: got %0d required 0", ack1_cnt);
    end
    if (fd_cnt !== 1) begin
      n_errors++;
      $display("FAIL mask frame_done count: got %0d required 1", fd_cnt);
    end
    if (fd_ch !== 2) begin
      n_errors++;
      $display("FAIL mask frame_done channel: got %0d required 2", fd_ch);
    end
    req = '0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    ch_en = '1;
    sample_flat[4*DW +: DW] = DW'($urandom_range(1, 4095));
    sample_flat[2*DW +: DW] = DW'($urandom_range(0, 4095));
    sample_flat[6*DW +: DW] = DW'($urandom_range(0, 4095));
    req = ch_bit(4);
    @(negedge clk);
    n_checks++;
    if (ack !== ch_bit(4)) begin
      n_errors++;
      $display("FAIL midrst ack4: got %h required %h", ack, ch_bit(4));
    end
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks += 3;
      if ({ack, scl_in, res_valid, res_ch, frame_done} !== {m_ack, m_scl, m_rv, m_rch, m_fd}) begin
        n_errors++;
        $display("FAIL midrst c%0d outputs: got %h required %h", c,
                 {ack, scl_in, res_valid, res_ch, frame_done}, {m_ack, m_scl, m_rv, m_rch, m_fd});
      end
      if (res_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL midrst res_valid c%0d: got %b required 0", c, res_valid);
      end
      if (res_flat !== '0) begin
        n_errors++;
        $display("FAIL midrst bank c%0d: got %h required 0", c, res_flat);
      end
    end
    req = ch_bit(2) | ch_bit(6);
    @(negedge clk);
    n_checks++;
    if (ack !== ch_bit(2)) begin
      n_errors++;
      $display("FAIL midrst first grant: got %h required %h", ack, ch_bit(2));
    end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) ch_en = ($urandom_range(0, 7) == 0) ? 13'd0 : N_CH'($urandom);
      @(negedge clk);
      n_checks += 2;
      if ({ack, scl_in, res_valid, res_ch, frame_done} !== {m_ack, m_scl, m_rv, m_rch, m_fd}) begin
        n_errors++;
        $display("FAIL random c%0d outputs: got %h required %h", c,
                 {ack, scl_in, res_valid, res_ch, frame_done}, {m_ack, m_scl, m_rv, m_rch, m_fd});
      end
      if (res_flat !== m_bank) begin
        n_errors++;
        $display("FAIL random c%0d bank: got %h required %h", c, res_flat, m_bank);
      end
      for (int k = 0; k < int'(N_CH); k++) begin
        if (ack[k]) req[k] = 1'b0;
        else if ($urandom_range(0, 3) == 0) req[k] = ~req[k];
        if (!req[k]) sample_flat[k*DW +: DW] = DW'($urandom_range(0, 4095));
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_channels();
    test_alternate();
    test_single_hold();
    test_enable_mask();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
